me_stage: RTL and testbench
===========================

# me_stage

Memory stage of the five-stage MIPS pipeline. Consumes the EX/ME pipeline-register outputs: ALU result, store data, destination register and the mem2reg/memwr/regwr controls. Performs the data-memory access and registers the write-back bundle into the ME/WB pipeline register. Also exposes ME-stage forwarding data to the hazard/forwarding unit.

## Interface
Parameters:
- AW, 10, word-address width of the data RAM (2^AW 32-bit words).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset; synchronous and active-high.
- stall  in  1  hold the ME/WB register and suppress the memory write this cycle.
- flush  in  1  kill the instruction in ME: suppress the write and load a bubble into ME/WB.
- alu_res  in  32  byte address for load/store; result value for ALU instructions.
- st_data  in  32  store data.
- rd  in  5  destination register.
- mem2reg  in  1  instruction is a load.
- memwr  in  1  instruction is a store.
- regwr  in  1  instruction writes the register file.
- wb_data  out  32  ME/WB: load data or ALU result.
- wb_rd  out  5  ME/WB destination register.
- wb_regwr  out  1  ME/WB write enable.
- fwd_rd  out  5  combinational copy of rd, for forwarding.
- fwd_regwr  out  1  combinational: regwr & ~mem2reg & ~flush. Loads cannot be forwarded from ME.
- fwd_data  out  32  combinational copy of alu_res.
- err_misalign  out  1  sticky: a load or store used a non-word-aligned address.

## Operation
- Word index = alu_res[AW+1:2]. Address bits above AW+1 are ignored, so addresses wrap modulo 2^AW words.
- Aligned means alu_res[1:0] == 0.
- **Store:** RAM[index] <= st_data at posedge when memwr & aligned & ~stall & ~flush. Otherwise RAM is unchanged.
- **Load:** asynchronous RAM read. The selected value = RAM[index] if aligned, else 32'h0.
- **ME/WB input mux:** wb_data_next = mem2reg ? loaded value : alu_res.
- **ME/WB update priority**, evaluated at each posedge:
  1. rst: wb_data=0, wb_rd=0, wb_regwr=0, err_misalign=0.
  2. flush: wb_data=0, wb_rd=0, wb_regwr=0. err_misalign is not updated.
  3. stall: all ME/WB fields hold. err_misalign is not updated.
  4. Otherwise: load {wb_data_next, rd, regwr}. err_misalign |= (mem2reg | memwr) & ~aligned.
- **Misaligned instruction:** the store is dropped; a load writes back 0 with regwr unchanged; the error flag is set.
- **mem2reg and memwr both high:** the store occurs, and the load returns the pre-store contents (read-before-write).
- RAM contents are not cleared by rst. The bench initialises the RAM via hierarchical $readmemh or stores.

## Timing
- Latency: EX/ME inputs appear on the wb_* outputs one posedge after capture.
- The forwarding outputs are purely combinational from the inputs (zero latency).
- A store is visible to a load in the next cycle. A store immediately followed by a load of the same word returns the new data.
- Write-back data is never produced combinationally; the RF write happens in the cycle after ME/WB is loaded.
- Reset mid-operation: ME/WB and the error flag clear at that posedge. A write presented in the reset cycle is suppressed (rst masks the write enable).
- stall and flush together: flush wins, and the write is suppressed.
- Out of reset, the outputs are wb_data=0, wb_rd=0, wb_regwr=0, err_misalign=0. The fwd_* outputs follow the inputs.

## Structure
- Shared package `mips_pkg`:
  - DATA_W=32, REG_W=5.
  - Struct `mewb_t` {data, rd, regwr}.
  - Constant `MEWB_BUBBLE` (all-zero), shared with the future WB-stage and hazard unit.
- Sub-module `data_ram`:
  - Single-port, async read, sync write.
  - Ports clk, we, addr[AW-1:0], wdata, rdata.
  - The rst mask on we lives in me_stage, not in the RAM.
- Everything else (alignment check, mux, ME/WB register, error flag) is in me_stage.

## Test plan
- **Store then load:** store 32'hDEADBEEF to 0x10; next cycle load 0x10 with rd=5, regwr=1, mem2reg=1. One cycle later: wb_data=DEADBEEF, wb_rd=5, wb_regwr=1.
- **ALU pass-through and forwarding:** alu_res=0x1234, rd=7, regwr=1, mem2reg=0. fwd_data=0x1234 and fwd_regwr=1 in the same cycle; wb_data=0x1234 after one posedge. The same vector with mem2reg=1 gives fwd_regwr=0.
- **Stall/flush:** stall=1 with a store of 0xAA to 0x20 leaves 0x20 unchanged and wb_* held. stall=1 and flush=1 together give wb_regwr=0, wb_data=0, and no write.
- **Misalignment:** store to 0x22 leaves RAM[8] unchanged and err_misalign=1 after the posedge. A later aligned load keeps the flag at 1; rst clears it.
- **Wrap:** with AW=10, a store to 0x1000 then a load from 0x0 returns the stored value.
- **Reset mid-stream:** rst asserted together with a store to 0x40 suppresses the write, gives wb_*=0, and a subsequent load of 0x40 returns the prior contents.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the ME stage, and later by the WB stage
// and the hazard unit.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
        logic              regwr;
    } mewb_t;

    // A bubble writes nothing and carries zero data.
    localparam mewb_t MEWB_BUBBLE = '0;

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM with asynchronous read and synchronous write.
// Contents are not cleared by any reset.
module data_ram
    import mips_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // The read is combinational, so a store and a load in the same cycle see the old word.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/me_stage.sv
// MIPS memory stage: data RAM access, the ME/WB pipeline register, ME-stage forwarding taps
// and a sticky misalignment flag.
module me_stage
    import mips_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] alu_res,
    input  logic [31:0] st_data,
    input  logic [4:0]  rd,
    input  logic        mem2reg,
    input  logic        memwr,
    input  logic        regwr,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwr,
    output logic [4:0]  fwd_rd,
    output logic        fwd_regwr,
    output logic [31:0] fwd_data,
    output logic        err_misalign
);

    logic              aligned;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] ld_val;
    mewb_t             mewb_q;
    mewb_t             mewb_d;
    logic              err_q;
    logic              err_d;

    assign aligned  = (alu_res[1:0] == 2'b00);
    // Upper address bits are dropped, so addresses wrap modulo the RAM size.
    assign ram_addr = alu_res[AW+1:2];
    assign ram_we   = memwr & aligned & ~stall & ~flush & ~rst;
    assign ld_val   = aligned ? ram_rdata : '0;

    data_ram #(
        .AW(AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(st_data),
        .rdata(ram_rdata)
    );

    always_comb begin
        mewb_d = mewb_q;
        err_d  = err_q;
        if (flush) begin
            mewb_d = MEWB_BUBBLE;
        end else if (!stall) begin
            mewb_d.data  = mem2reg ? ld_val : alu_res;
            mewb_d.rd    = rd;
            mewb_d.regwr = regwr;
            err_d        = err_q | ((mem2reg | memwr) & ~aligned);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mewb_q <= MEWB_BUBBLE;
            err_q  <= 1'b0;
        end else begin
            mewb_q <= mewb_d;
            err_q  <= err_d;
        end
    end

    assign wb_data      = mewb_q.data;
    assign wb_rd        = mewb_q.rd;
    assign wb_regwr     = mewb_q.regwr;
    assign err_misalign = err_q;

    // Load data is not available until WB, so loads are never forwarded from here.
    assign fwd_rd    = rd;
    assign fwd_regwr = regwr & ~mem2reg & ~flush;
    assign fwd_data  = alu_res;

endmodule

// File: tb/tb_me_stage.sv
// Directed bench for me_stage with hand-computed expected values.
module tb_me_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] alu_res, st_data;
    logic [4:0]  rd;
    logic        mem2reg, memwr, regwr;
    logic [31:0] wb_data, fwd_data;
    logic [4:0]  wb_rd, fwd_rd;
    logic        wb_regwr, fwd_regwr, err_misalign;

    int n_chk  = 0;
    int n_pass = 0;

    me_stage #(.AW(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .alu_res     (alu_res),
        .st_data     (st_data),
        .rd          (rd),
        .mem2reg     (mem2reg),
        .memwr       (memwr),
        .regwr       (regwr),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_regwr    (wb_regwr),
        .fwd_rd      (fwd_rd),
        .fwd_regwr   (fwd_regwr),
        .fwd_data    (fwd_data),
        .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                         input logic m2r, input logic mw, input logic rw);
        alu_res = a;
        st_data = sd;
        rd      = r;
        mem2reg = m2r;
        memwr   = mw;
        regwr   = rw;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
        chk("rst_wb_regwr", {31'h0, wb_regwr}, 32'h0);
        chk("rst_err", {31'h0, err_misalign}, 32'h0);
        rst = 1'b0;

        // store then load
        drive(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("ld_fwd_regwr", {31'h0, fwd_regwr}, 32'h0);
        cyc();
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_rd", {27'h0, wb_rd}, 32'd5);
        chk("ld_wb_regwr", {31'h0, wb_regwr}, 32'h1);

        // ALU pass-through and forwarding
        drive(32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1);
        chk("alu_fwd_data", fwd_data, 32'h1234);
        chk("alu_fwd_regwr", {31'h0, fwd_regwr}, 32'h1);
        chk("alu_fwd_rd", {27'h0, fwd_rd}, 32'd7);
        flush = 1'b1; #1;
        chk("flush_fwd_regwr", {31'h0, fwd_regwr}, 32'h0);
        flush = 1'b0; #1;
        cyc();
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", {27'h0, wb_rd}, 32'd7);
        drive(32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
        chk("m2r_fwd_regwr", {31'h0, fwd_regwr}, 32'h0);

        // stall holds ME/WB and blocks the store
        drive(32'h20, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(32'h777, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
        cyc();
        stall = 1'b1;
        drive(32'h20, 32'hAA, 5'd9, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("stall_wb_data", wb_data, 32'h777);
        chk("stall_wb_rd", {27'h0, wb_rd}, 32'd3);
        chk("stall_wb_regwr", {31'h0, wb_regwr}, 32'h1);
        stall = 1'b0;
        drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("stall_nowrite", wb_data, 32'h55);

        // stall and flush together: bubble, no write
        stall = 1'b1; flush = 1'b1;
        drive(32'h20, 32'hBB, 5'd9, 1'b0, 1'b1, 1'b1);
        cyc();
        chk("sf_wb_data", wb_data, 32'h0);
        chk("sf_wb_rd", {27'h0, wb_rd}, 32'h0);
        chk("sf_wb_regwr", {31'h0, wb_regwr}, 32'h0);
        stall = 1'b0; flush = 1'b0;
        drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("sf_nowrite", wb_data, 32'h55);
        chk("pre_mis_err", {31'h0, err_misalign}, 32'h0);

        // misalignment
        drive(32'h22, 32'hCC, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("mis_st_err", {31'h0, err_misalign}, 32'h1);
        drive(32'h21, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("mis_ld_data", wb_data, 32'h0);
        chk("mis_ld_regwr", {31'h0, wb_regwr}, 32'h1);
        drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("mis_st_dropped", wb_data, 32'h55);
        chk("mis_err_sticky", {31'h0, err_misalign}, 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mis_err_rst", {31'h0, err_misalign}, 32'h0);

        // address wrap
        drive(32'h1000, 32'h0BADF00D, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("wrap_data", wb_data, 32'h0BADF00D);
        chk("wrap_err", {31'h0, err_misalign}, 32'h0);

        // reset mid-stream suppresses the write
        drive(32'h40, 32'h11112222, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        rst = 1'b1;
        drive(32'h40, 32'h33334444, 5'd8, 1'b0, 1'b1, 1'b1);
        cyc();
        rst = 1'b0;
        chk("rstw_wb_data", wb_data, 32'h0);
        chk("rstw_wb_regwr", {31'h0, wb_regwr}, 32'h0);
        drive(32'h40, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("rstw_nowrite", wb_data, 32'h11112222);

        // load and store together: read-before-write
        drive(32'h40, 32'h5A5A5A5A, 5'd1, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("rbw_old", wb_data, 32'h11112222);
        drive(32'h40, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("rbw_new", wb_data, 32'h5A5A5A5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
